// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 streaming convolution engine.
//   DEFAULT_KERNEL : reset-time kernel (sums to 128, so with a shift of 7 it is unity gain)
//   coef_arr_t     : 9-entry kernel container, raster order (0 = top-left)
//   acc_width()    : accumulator width needed to sum nine pixel*coefficient products
//   sat()          : clamp a wide signed value into a dout_w-bit signed range
package conv_pkg;

    localparam int KERNEL_N = 9;

    typedef logic signed [31:0] coef_arr_t [KERNEL_N];

    localparam coef_arr_t DEFAULT_KERNEL = '{
        32'sd8,  32'sd16, 32'sd8,
        32'sd16, 32'sd32, 32'sd16,
        32'sd8,  32'sd16, 32'sd8
    };

    // Each product is din_w+coef_w+1 bits; nine of them need four more bits of headroom.
    function automatic int acc_width(input int din_w, input int coef_w);
        return din_w + coef_w + 5;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int dout_w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (dout_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Two cascaded row delay lines for the 3x3 window.
//   clk  : clock
//   en   : shift one pixel in (tied to the input handshake)
//   din  : incoming pixel
//   tap1 : pixel accepted DEPTH shifts ago (same column, previous row)
//   tap2 : pixel accepted 2*DEPTH shifts ago (same column, two rows up)
// Storage has no reset: stale contents only ever reach windows that are not flagged valid.
module line_buffer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap1,
    output logic [WIDTH-1:0] tap2
);

    logic [WIDTH-1:0] row0_r [DEPTH];
    logic [WIDTH-1:0] row1_r [DEPTH];

    // Shift both rows by one pixel; row1 is fed from the tail of row0.
    always_ff @(posedge clk) begin
        if (en) begin
            row0_r[0] <= din;
            row1_r[0] <= row0_r[DEPTH-1];
            for (int i = 1; i < DEPTH; i++) begin
                row0_r[i] <= row0_r[i-1];
                row1_r[i] <= row1_r[i-1];
            end
        end
    end

    assign tap1 = row0_r[DEPTH-1];
    assign tap2 = row1_r[DEPTH-1];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution, valid-mode output in raster order.
//   clk, rst              : clock, synchronous active-high reset
//   coef_we/addr/wdata    : kernel write port (applied only while idle, addr 0..8)
//   in_valid/ready/data   : pixel stream in, frame position implied by count
//   out_valid/ready/data  : signed result stream out
//   out_last              : last result of a frame
//   busy                  : frame in progress or results still pending
// Pipeline: S1 products, S2 accumulate, S3 shift+saturate (output register).
// A single stall (output held and not taken) freezes every stage and the window.
module conv3x3_stream #(
    parameter int IMG_W     = 8,
    parameter int IMG_H     = 8,
    parameter int DIN_W     = 8,
    parameter int COEF_W    = 8,
    parameter int OUT_SHIFT = 7,
    parameter int DOUT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    import conv_pkg::*;

    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int PROD_W = DIN_W + COEF_W + 1;
    localparam int ACC_W  = acc_width(DIN_W, COEF_W);

    logic [CW-1:0]            col_r;
    logic [RW-1:0]            row_r;
    logic signed [COEF_W-1:0] coef_r [KERNEL_N];
    logic [DIN_W-1:0]         win_r [3][2];
    logic [DIN_W-1:0]         pix_s [KERNEL_N];
    logic [DIN_W-1:0]         tap1_s;
    logic [DIN_W-1:0]         tap2_s;
    logic signed [PROD_W-1:0] prod_r [KERNEL_N];
    logic signed [ACC_W-1:0]  acc_sum_s;
    logic signed [ACC_W-1:0]  acc_r;
    logic                     s1_valid_r, s1_last_r;
    logic                     s2_valid_r, s2_last_r;
    logic                     out_valid_r, out_last_r, busy_r;
    logic [DOUT_W-1:0]        out_data_r;

    logic stall_s, accept_s, first_px_s, last_px_s, win_ok_s, out_hs_s, frame_end_s;

    assign stall_s     = out_valid_r && !out_ready;
    assign in_ready    = !stall_s && !rst;
    assign accept_s    = in_valid && in_ready;
    assign first_px_s  = accept_s && (row_r == '0) && (col_r == '0);
    assign last_px_s   = accept_s && (row_r == RW'(IMG_H - 1)) && (col_r == CW'(IMG_W - 1));
    assign win_ok_s    = accept_s && (row_r >= RW'(2)) && (col_r >= CW'(2));
    assign out_hs_s    = out_valid_r && out_ready;
    // Counters back at (0,0) with nothing accepted means no later frame has started yet.
    assign frame_end_s = out_hs_s && out_last_r && !accept_s && (row_r == '0) && (col_r == '0);

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (DIN_W)
    ) u_line_buffer (
        .clk  (clk),
        .en   (accept_s),
        .din  (in_data),
        .tap1 (tap1_s),
        .tap2 (tap2_s)
    );

    // Column/row position of the next pixel; wraps straight into the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r <= '0;
            row_r <= '0;
        end else if (accept_s) begin
            if (col_r == CW'(IMG_W - 1)) begin
                col_r <= '0;
                if (row_r == RW'(IMG_H - 1)) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + RW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Kernel registers; writes are honoured only between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < KERNEL_N; k++) begin
                coef_r[k] <= COEF_W'(DEFAULT_KERNEL[k]);
            end
        end else if (coef_we && !busy_r && (coef_addr <= 4'd8)) begin
            for (int k = 0; k < KERNEL_N; k++) begin
                if (coef_addr == 4'(k)) begin
                    coef_r[k] <= coef_wdata;
                end
            end
        end
    end

    // Current window: two registered columns plus the column arriving this cycle.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            pix_s[r*3]     = win_r[r][0];
            pix_s[r*3 + 1] = win_r[r][1];
        end
        pix_s[2] = tap2_s;
        pix_s[5] = tap1_s;
        pix_s[8] = in_data;
    end

    // Shift the window left by one column on every accepted pixel.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_r[r][0] <= win_r[r][1];
                win_r[r][1] <= pix_s[r*3 + 2];
            end
        end
    end

    // S1 datapath: nine signed products (pixel zero-extended to stay positive).
    always_ff @(posedge clk) begin
        if (!stall_s) begin
            for (int k = 0; k < KERNEL_N; k++) begin
                prod_r[k] <= PROD_W'($signed({1'b0, pix_s[k]})) * PROD_W'(coef_r[k]);
            end
        end
    end

    // S2 sum of products, sign-extended to the accumulator width.
    always_comb begin
        acc_sum_s = '0;
        for (int k = 0; k < KERNEL_N; k++) begin
            acc_sum_s = acc_sum_s + ACC_W'(prod_r[k]);
        end
    end

    // S2 datapath register.
    always_ff @(posedge clk) begin
        if (!stall_s) begin
            acc_r <= acc_sum_s;
        end
    end

    // Pipeline control: valid and last flags follow the data one stage per unstalled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_last_r   <= 1'b0;
            s2_valid_r  <= 1'b0;
            s2_last_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
        end else if (!stall_s) begin
            s1_valid_r  <= win_ok_s;
            s1_last_r   <= last_px_s;
            s2_valid_r  <= s1_valid_r;
            s2_last_r   <= s1_valid_r && s1_last_r;
            out_valid_r <= s2_valid_r;
            out_last_r  <= s2_valid_r && s2_last_r;
            if (s2_valid_r) begin
                out_data_r <= DOUT_W'(sat(64'(acc_r) >>> OUT_SHIFT, DOUT_W));
            end
        end
    end

    // Busy spans first pixel of a frame through the handshake of its last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
        end else if (first_px_s) begin
            busy_r <= 1'b1;
        end else if (frame_end_s) begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Streaming 3x3 2D convolution engine for IMG_W x IMG_H frames of unsigned pixels.
- Applies a run-time programmable signed fixed-point kernel and produces the valid-mode (IMG_W-2)x(IMG_H-2) output in raster order.
- Uses two-row line buffers instead of whole-frame storage; ready/valid handshakes on both sides.
- Sits between the pixel RAM reader and the result writer in the convolution datapath.

Parameters:
- IMG_W, 8, pixels per row (>=3)
- IMG_H, 8, rows per frame (>=3)
- DIN_W, 8, unsigned pixel width
- COEF_W, 8, signed coefficient width, Q1.(COEF_W-1)
- OUT_SHIFT, 7, arithmetic right shift applied to the accumulator before saturation
- DOUT_W, 16, signed output width

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  kernel index 0..8, raster order (0 = top-left)
- coef_wdata  in  COEF_W  signed coefficient
- in_valid  in  1  pixel offered
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_data  in  DIN_W  pixel, raster order, frame boundaries implied by count
- out_valid  out  1  result offered
- out_ready  in  1  consumer accepts
- out_data  out  DOUT_W  signed result
- out_last  out  1  marks last result of a frame
- busy  out  1  frame in progress or results pending

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_data=0, out_last=0, busy=0. in_ready=0 during reset and 1 from the cycle after. Column and row counters are zeroed, pipeline valids cleared, and coefficients restored to the default {8,16,8,16,32,16,8,16,8}. Line-buffer contents are don't-care.
- Reset mid-frame discards all partial state; the next accepted pixel is pixel (0,0).
- Input side: col counts 0..IMG_W-1, then row counts 0..IMG_H-1, both wrapping. After pixel (IMG_H-1, IMG_W-1), the next accepted pixel is (0,0) of the next frame with no idle cycle required.
- Window: a 3x3 shift-register window is fed from the two line buffers plus in_data. A window is valid when the accepted pixel has row>=2 && col>=2. The output is centred on (row-1, col-1).
- Pipeline, 3 stages:
  - S1: nine products, each DIN_W+COEF_W+1 bits signed.
  - S2: adder tree into ACC_W = DIN_W+COEF_W+5 bits signed.
  - S3: arithmetic >>OUT_SHIFT, then saturate to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]; this stage is the output register.
- Latency: out_valid rises exactly 3 cycles after the handshake of the window-completing pixel, absent backpressure.
- Stall: stall = out_valid && !out_ready. All stages and the window/line buffers hold when stalled. in_ready = !stall && !rst. out_data and out_last are stable while out_valid && !out_ready.
- Throughput: 1 pixel/cycle. No output is lost or duplicated under arbitrary out_ready patterns.
- out_last=1 only with the result centred on (IMG_H-2, IMG_W-2).
- busy: set on the first pixel handshake of a frame. Cleared on the handshake of the out_last result, unless a new frame's pixel is accepted in the same cycle.
- Coefficients:
  - Writes are applied at posedge only when busy=0 and coef_addr<=8.
  - Writes while busy=1, or with coef_addr>8, are silently dropped.
  - A coefficient written in cycle N is used by every window of any frame whose first pixel is accepted after N.
- Simultaneous events: coef_we in the same cycle as the first pixel handshake of a frame (busy still 0) is applied and takes effect for that frame.

Decomposition:
- Package conv_pkg:
  - Default kernel constant array.
  - Function acc_width(DIN_W, COEF_W) for ACC_W.
  - Function sat(value, DOUT_W).
  - Typedef for the 9-entry coefficient array.
- Sub-module line_buffer: parametrised depth IMG_W and width DIN_W, two rows cascaded, with enable input and no reset on storage.

Test Plan:
- Default kernel, 8x8 frame of all 100, out_ready=1 -> 36 results of 100. First out_valid 3 cycles after the 19th pixel handshake. out_last on the 36th. busy falls after it.
- Identity kernel (coef4=127, others 0), OUT_SHIFT=7, ramp p(r,c)=r*8+c -> out(i,j)=floor(p(i+1,j+1)*127/128). First result 8, last 53.
- OUT_SHIFT=0:
  - All coefs 127 with pixels 255 -> every result 32767 (saturation from 291465).
  - All coefs -128 -> every result -32768.
- Random 50% out_ready on scenario 1, back-to-back second frame -> 72 results of 100 in order, exactly two out_last. in_ready=0 whenever out_valid&&!out_ready.
- coef_we (addr 4, value 0) during frame 1 -> frame 1 results unchanged (100). Same write after busy=0 -> frame 2 results 75. Write with addr 12 -> no effect.
- rst asserted after 30 pixels -> next cycle out_valid=0, busy=0. A full new frame yields exactly 36 correct results with the default kernel.
